// File: rtl/beta_cache_pkg.sv
// Shared types and address-field width helpers for the beta data cache.
package beta_cache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cache_state_t;

    function automatic int unsigned offset_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Offset field is kept at least one bit wide so single-word lines still have a legal vector.
    function automatic int unsigned offset_w(input int unsigned line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned sets, input int unsigned line_words);
        return ADDR_W - 2 - $clog2(line_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/beta_cache_way.sv
// One cache way: valid bits, tag array and data array with combinational lookup.
module beta_cache_way
    import beta_cache_pkg::*;
#(
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned IW = index_w(SETS),
    localparam int unsigned TW = tag_w(SETS, LINE_WORDS),
    localparam int unsigned OW = offset_w(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     index,
    input  logic [TW-1:0]     tag,
    input  logic [OW-1:0]     rd_offset,
    input  logic [OW-1:0]     wr_offset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              tag_we,
    input  logic              inv_en,
    input  logic              flush_all,
    output logic              hit_c,
    output logic              valid_c,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = SETS * LINE_WORDS;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TW-1:0]     tag_mem  [SETS];
    logic [SETS-1:0]   valid_q, valid_d;
    logic [AW-1:0]     rd_ptr, wr_ptr;

    assign rd_ptr = AW'(index) * AW'(LINE_WORDS) + AW'(rd_offset);
    assign wr_ptr = AW'(index) * AW'(LINE_WORDS) + AW'(wr_offset);

    // Flush has the last word so a global invalidate always wins.
    always_comb begin
        valid_d = valid_q;
        if (inv_en) valid_d[index] = 1'b0;
        if (tag_we) valid_d[index] = 1'b1;
        if (flush_all) valid_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en)  data_mem[wr_ptr] <= wr_data;
        if (tag_we) tag_mem[index]   <= tag;
    end

    assign valid_c = valid_q[index];
    assign hit_c   = valid_c && (tag_mem[index] == tag);
    assign rdata_c = data_mem[rd_ptr];

endmodule

// File: rtl/beta_cache_ctl.sv
// Write-through, read-allocate set-associative data cache controller for the beta CPU.
module beta_cache_ctl
    import beta_cache_pkg::*;
#(
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned OB = offset_bits(LINE_WORDS);
    localparam int unsigned OW = offset_w(LINE_WORDS);
    localparam int unsigned IW = index_w(SETS);
    localparam int unsigned TW = tag_w(SETS, LINE_WORDS);
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    cache_state_t    state_q, state_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;
    logic [OW-1:0]   word_cnt_q, word_cnt_d;
    logic            victim_q, victim_d;
    logic            flush_pend_q, flush_pend_d;
    logic [SETS-1:0] lru_q, lru_d;

    logic [31:0]     lk_addr;
    logic [IW-1:0]   lk_index;
    logic [TW-1:0]   lk_tag;
    logic [OW-1:0]   lk_offset, wr_offset;
    logic [31:0]     way_wdata;
    logic [WAYS-1:0] way_hit, way_valid, word_we, tag_we, inv_en;
    logic [31:0]     way_rdata [WAYS];
    logic            hit_any, hit_way, victim_c, last_word, flush_all;
    logic [31:0]     hit_rdata;

    // While a transfer is in flight the lookup follows the latched request, not the CPU bus.
    assign lk_addr   = (state_q == IDLE) ? cpu_addr : req_addr_q;
    assign lk_offset = OW'((lk_addr >> 2) & 32'(LINE_WORDS - 1));
    assign lk_index  = IW'(lk_addr >> (2 + OB));
    assign lk_tag    = TW'(lk_addr >> (2 + OB + IW));
    assign wr_offset = (state_q == FILL) ? word_cnt_q : lk_offset;
    assign way_wdata = (state_q == FILL) ? mem_rdata : wdata_q;
    assign last_word = (word_cnt_q == OW'(LINE_WORDS - 1));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        beta_cache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .index     (lk_index),
            .tag       (lk_tag),
            .rd_offset (lk_offset),
            .wr_offset (wr_offset),
            .wr_data   (way_wdata),
            .wr_en     (word_we[w]),
            .tag_we    (tag_we[w]),
            .inv_en    (inv_en[w]),
            .flush_all (flush_all),
            .hit_c     (way_hit[w]),
            .valid_c   (way_valid[w]),
            .rdata_c   (way_rdata[w])
        );
    end

    always_comb begin
        hit_rdata = '0;
        hit_way   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_rdata = hit_rdata | way_rdata[w];
                hit_way   = 1'(w);
            end
        end
    end

    assign hit_any = |way_hit;

    // Victim: first invalid way, otherwise the way the LRU bit points at.
    always_comb begin
        victim_c = 1'b0;
        if (WAYS == 2) begin
            if (!way_valid[0])           victim_c = 1'b0;
            else if (!way_valid[WAYS-1]) victim_c = 1'b1;
            else                         victim_c = lru_q[lk_index];
        end
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        wdata_d      = wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        word_cnt_d   = word_cnt_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        lru_d        = lru_q;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        word_we      = '0;
        tag_we       = '0;
        inv_en       = '0;
        flush_all    = 1'b0;

        case (state_q)
            IDLE: begin
                flush_all    = flush | flush_pend_q;
                flush_pend_d = 1'b0;
                if (cpu_wr) begin
                    state_d    = WRITE;
                    req_addr_d = {cpu_addr[31:2], 2'b00};
                    wdata_d    = cpu_wdata;
                end else if (cpu_rd) begin
                    if (hit_any) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = hit_rdata;
                        hit_cnt_d = hit_cnt_q + 32'd1;
                        if (WAYS == 2) lru_d[lk_index] = ~hit_way;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        state_d    = FILL;
                        req_addr_d = {cpu_addr[31:2], 2'b00};
                        word_cnt_d = '0;
                        victim_d   = victim_c;
                        for (int w = 0; w < WAYS; w++) begin
                            if (victim_c == 1'(w)) inv_en[w] = 1'b1;
                        end
                    end
                end
            end

            FILL: begin
                mem_rd       = 1'b1;
                mem_addr     = (req_addr_q & ~LINE_MASK) | (32'(word_cnt_q) << 2);
                flush_pend_d = flush_pend_q | flush;
                if (mem_ready) begin
                    word_cnt_d = word_cnt_q + OW'(1);
                    for (int w = 0; w < WAYS; w++) begin
                        if (victim_q == 1'(w)) begin
                            word_we[w] = 1'b1;
                            tag_we[w]  = last_word;
                        end
                    end
                    if (last_word) state_d = IDLE;
                end
            end

            WRITE: begin
                mem_wr       = 1'b1;
                mem_addr     = req_addr_q;
                mem_wdata    = wdata_q;
                flush_pend_d = flush_pend_q | flush;
                if (mem_ready) begin
                    cpu_ready = 1'b1;
                    word_we   = way_hit;
                    if (hit_any && WAYS == 2) lru_d[lk_index] = ~hit_way;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            wdata_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            word_cnt_q   <= '0;
            victim_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            wdata_q      <= wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            word_cnt_q   <= word_cnt_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            lru_q        <= lru_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: doc/beta_cache_ctl.md
Name: beta_cache_ctl

Overview:
- Parametrised, set-associative, write-through read cache for the beta CPU data port. Replaces the fixed hit/miss stub with a real tag/data store, a burst line refill and perf counters.
- Sits between the CPU memory port (memAddr/memWriteData/MemRead/MemWrite) and the external memory handshake (MemReadReady/memReadData).
- Hits complete in the same cycle, so the single-cycle datapath does not stall. Misses and writes stall the CPU through cpu_ready.

Parameters:
SETS, 16, number of sets; power of 2, >=2
WAYS, 2, associativity; legal values 1 or 2
LINE_WORDS, 4, 32-bit words per line; power of 2, >=1

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
cpu_rd  in  1  CPU load request
cpu_wr  in  1  CPU store request
cpu_addr  in  32  byte address; bits [1:0] ignored
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data; valid when cpu_ready=1 and cpu_rd=1
cpu_ready  out  1  request completes this cycle; 0 = stall
flush  in  1  invalidate all lines
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_addr  out  32  word-aligned memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
mem_ready  in  1  memory ack; one pulse per word transferred
hit_cnt  out  32  load hits since reset, wraps
miss_cnt  out  32  load misses since reset, wraps

Behaviour:
- Address split:
  - word offset = cpu_addr[2 +: OB], where OB = log2(LINE_WORDS)
  - index = next log2(SETS) bits
  - tag = the remaining upper bits
- Reset (reset=0, async):
  - all valid bits and LRU bits cleared; state=IDLE
  - outputs mem_rd, mem_wr, cpu_ready, mem_addr, mem_wdata, cpu_rdata = 0
  - counters = 0
  - Reset during FILL or WRITE aborts the transfer immediately; mem_rd and mem_wr drop asynchronously.
- FSM states are IDLE, FILL and WRITE.
- IDLE, cpu_rd, hit:
  - cpu_ready=1 combinationally; cpu_rdata = matching way's word
  - hit_cnt++ at the edge
  - for WAYS=2, the LRU bit is set to point at the other way
- IDLE, cpu_rd, miss:
  - cpu_ready=0; miss_cnt++ once; go to FILL
  - victim selection, WAYS=2: the invalid way if one exists (way0 preferred), else the LRU way. WAYS=1: way0.
- FILL:
  - mem_rd=1; mem_addr = {tag,index,word_cnt,2'b00}, held stable until mem_ready
  - word_cnt starts at 0 on FILL entry
  - each mem_ready cycle writes mem_rdata into victim[word_cnt] and increments word_cnt
  - when word_cnt reaches LINE_WORDS-1 and mem_ready=1: tag is written, valid=1, go to IDLE
  - the load then hits on the next cycle; that hit is counted in hit_cnt
- IDLE, cpu_wr (write-through, no-write-allocate):
  - go to WRITE; mem_wr=1; mem_addr={cpu_addr[31:2],2'b00}; mem_wdata=cpu_wdata
  - on mem_ready: if the address hits, the cached word is updated and LRU is touched; cpu_ready=1 that cycle; go to IDLE
  - a write miss does not allocate
- cpu_rd and cpu_wr both high: cpu_wr wins; the read is treated as absent.
- mem_ready while in IDLE is ignored.
- flush:
  - in IDLE, all valid bits are cleared at the edge; a same-cycle hit is still served
  - in FILL or WRITE, the flush is latched as pending and applied on the cycle the FSM returns to IDLE, after the fill completes, so the just-filled line is also invalidated
- Counters wrap from 0xFFFFFFFF to 0.
- No X on any output after reset; the data array needs no reset.

Decomposition:
- Package beta_cache_pkg holds:
  - state enum cache_state_t {IDLE, FILL, WRITE}
  - width helper functions: offset, index and tag widths from the parameters
- One sub-module, beta_cache_way: a single way's tag/valid/data array with a combinational lookup and a synchronous line write port.
  - Instantiated WAYS times via a generate loop.
  - The controller holds the FSM, LRU, counters and muxing.

Test Plan:
- Cold load 0x0000_0010 (SETS=16, WAYS=2, LINE_WORDS=4):
  - mem_rd issued for 0x10, 0x14, 0x18, 0x1C, each acked after 2 wait cycles
  - cpu_ready=1 on the cycle after the last ack, with rdata = word 0x10
  - miss_cnt=1, hit_cnt=1
- Load 0x14 after the above -> cpu_ready=1 same cycle, no mem_rd, hit_cnt=2.
- LRU eviction, addresses 0x0000, 0x1000 and 0x2000 (same index):
  - load 0x0000, then load 0x1000, then load 0x0000 again (hit)
  - then load 0x2000: it evicts the 0x1000 line
  - a subsequent load 0x1000 misses; load 0x0000 hits
- Store 0x14 = 0xDEADBEEF on a resident line:
  - mem_wr with mem_addr=0x14 held until mem_ready
  - then load 0x14 hits, returning 0xDEADBEEF
  - a store to an absent line leaves the miss count unchanged on a later cold load
- Flush asserted mid-FILL -> the fill completes; the line is invalid afterwards; reloading it misses (miss_cnt +1).
- reset driven low mid-FILL -> mem_rd drops the same cycle; counters are 0; after release, every load misses.
